// File: rtl/vid_timing_gen.sv
// Video timing generator: free-running horizontal/vertical counters with
// porch/sync FSMs producing registered sync, blanking and start pulses.
//
// Ports:
//   rfr_clk     - pixel clock, rising edge active
//   reset_n     - asynchronous active-low reset
//   en          - timing advance enable; when low everything holds
//   pixel_cnt   - horizontal position, 0..H_TOTAL-1
//   line_cnt    - vertical position, 0..V_TOTAL-1
//   video_on    - high inside the active area
//   hsync       - horizontal sync, HS_POL when asserted
//   vsync       - vertical sync, VS_POL when asserted
//   line_start  - one-cycle pulse while pixel_cnt == 0
//   frame_start - one-cycle pulse while pixel_cnt == 0 and line_cnt == 0
module vid_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        rfr_clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [11:0] pixel_cnt,
    output logic [11:0] line_cnt,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
        $error("vid_timing_gen: illegal timing parameters");
    end

    localparam logic [11:0] HLast     = 12'(H_TOTAL - 1);
    localparam logic [11:0] VLast     = 12'(V_TOTAL - 1);
    localparam logic [11:0] HFrontBeg = 12'(H_ACTIVE);
    localparam logic [11:0] HSyncBeg  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HBackBeg  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VFrontBeg = 12'(V_ACTIVE);
    localparam logic [11:0] VSyncBeg  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VBackBeg  = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_e;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_e;

    h_state_e    h_state_q, h_state_d;
    v_state_e    v_state_q, v_state_d;
    logic        started_q, started_d;
    logic [11:0] pix_q, pix_d;
    logic [11:0] line_q, line_d;
    logic        video_on_q, video_on_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        pix_wrap;

    assign pix_wrap = (pix_q == HLast);

    // Counters and FSMs
    always_comb begin
        started_d = started_q;
        pix_d     = pix_q;
        line_d    = line_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (en) begin
            if (!started_q) begin
                // First enabled edge only arms the generator at (0,0).
                started_d = 1'b1;
                pix_d     = '0;
                line_d    = '0;
                h_state_d = H_ACT;
                v_state_d = V_ACT;
            end else begin
                if (pix_wrap) begin
                    pix_d  = '0;
                    line_d = (line_q == VLast) ? 12'd0 : line_q + 12'd1;
                end else begin
                    pix_d = pix_q + 12'd1;
                end

                case (h_state_q)
                    H_ACT:   if (pix_d == HFrontBeg) h_state_d = H_FRONT;
                    H_FRONT: if (pix_d == HSyncBeg)  h_state_d = H_SYNCP;
                    H_SYNCP: if (pix_d == HBackBeg)  h_state_d = H_BACK;
                    H_BACK:  if (pix_d == 12'd0)     h_state_d = H_ACT;
                    default: h_state_d = H_ACT;
                endcase

                // Vertical state only moves on pixel-wrap edges so vsync
                // changes coincide with pixel_cnt becoming 0.
                if (pix_wrap) begin
                    case (v_state_q)
                        V_ACT:   if (line_d == VFrontBeg) v_state_d = V_FRONT;
                        V_FRONT: if (line_d == VSyncBeg)  v_state_d = V_SYNCP;
                        V_SYNCP: if (line_d == VBackBeg)  v_state_d = V_BACK;
                        V_BACK:  if (line_d == 12'd0)     v_state_d = V_ACT;
                        default: v_state_d = V_ACT;
                    endcase
                end
            end
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the counters they describe.
    always_comb begin
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (en) begin
            video_on_d    = (pix_d < HFrontBeg) && (line_d < VFrontBeg);
            hsync_d       = (h_state_d == H_SYNCP) ? HS_POL : ~HS_POL;
            vsync_d       = (v_state_d == V_SYNCP) ? VS_POL : ~VS_POL;
            line_start_d  = (pix_d == 12'd0);
            frame_start_d = (pix_d == 12'd0) && (line_d == 12'd0);
        end
    end

    always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q     <= 1'b0;
            pix_q         <= '0;
            line_q        <= '0;
            h_state_q     <= H_ACT;
            v_state_q     <= V_ACT;
            video_on_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            started_q     <= started_d;
            pix_q         <= pix_d;
            line_q        <= line_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_cnt   = pix_q;
    assign line_cnt    = line_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed testbench for vid_timing_gen: a default 720p instance and a small
// negative-polarity instance (H 8/2/2/2, V 4/1/1/1) for full-frame checks.
module tb_vid_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Default-parameter instance
    logic        d_rst_n, d_en;
    logic [11:0] d_pix, d_line;
    logic        d_vid, d_hs, d_vs, d_ls, d_fs;

    vid_timing_gen u_dut_def (
        .rfr_clk     (clk),
        .reset_n     (d_rst_n),
        .en          (d_en),
        .pixel_cnt   (d_pix),
        .line_cnt    (d_line),
        .video_on    (d_vid),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .line_start  (d_ls),
        .frame_start (d_fs)
    );

    // Small negative-polarity instance
    logic        s_rst_n, s_en;
    logic [11:0] s_pix, s_line;
    logic        s_vid, s_hs, s_vs, s_ls, s_fs;

    vid_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0)
    ) u_dut_small (
        .rfr_clk     (clk),
        .reset_n     (s_rst_n),
        .en          (s_en),
        .pixel_cnt   (s_pix),
        .line_cnt    (s_line),
        .video_on    (s_vid),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_d(input int p, input int l, input int budget);
        int n = 0;
        while (!(d_pix == 12'(p) && d_line == 12'(l)) && n < budget) begin
            step();
            n++;
        end
        n_cmp++;
        if (d_pix !== 12'(p) || d_line !== 12'(l)) begin
            n_fail++;
            $display("FAIL run_to: reached (%0d,%0d) wanted (%0d,%0d)", d_pix, d_line, p, l);
        end
    endtask

    task automatic test_reset();
        d_rst_n = 1'b0; d_en = 1'b1;
        s_rst_n = 1'b0; s_en = 1'b1;
        step(); step();
        n_cmp++;
        if ({d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs} !== {12'd0, 12'd0, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_def: got %h/%h %b%b%b%b%b want 0/0 00000",
                     d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs);
        end
        n_cmp++;
        if ({s_pix, s_line, s_vid, s_hs, s_vs, s_ls, s_fs} !== {12'd0, 12'd0, 5'b01100}) begin
            n_fail++;
            $display("FAIL reset_small: got %h/%h %b%b%b%b%b want 0/0 01100",
                     s_pix, s_line, s_vid, s_hs, s_vs, s_ls, s_fs);
        end
    endtask

    task automatic test_first_edge();
        d_rst_n = 1'b1;
        step();
        n_cmp++;
        if ({d_pix, d_line, d_vid, d_ls, d_fs} !== {12'd0, 12'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL first_edge: got %0d/%0d vid=%b ls=%b fs=%b want 0/0 1 1 1",
                     d_pix, d_line, d_vid, d_ls, d_fs);
        end
        step();
        n_cmp++;
        if ({d_pix, d_line, d_vid, d_ls, d_fs} !== {12'd1, 12'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL second_edge: got %0d/%0d vid=%b ls=%b fs=%b want 1/0 1 0 0",
                     d_pix, d_line, d_vid, d_ls, d_fs);
        end
    endtask

    task automatic test_line();
        int vid_n = 0, hs_n = 0, ls_n = 0, pix_err = 0, hs_err = 0;
        int hs_first = -1, hs_last = -1;
        run_to_d(0, 1, 2000);
        for (int i = 0; i < 1650; i++) begin
            if (d_pix !== 12'(i) || d_line !== 12'd1) pix_err++;
            if (d_vid === 1'b1) vid_n++;
            if (d_ls === 1'b1) ls_n++;
            if (d_hs === 1'b1) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_hs !== ((i >= 1390 && i <= 1429) ? 1'b1 : 1'b0)) hs_err++;
            step();
        end
        n_cmp++;
        if (pix_err != 0) begin
            n_fail++; $display("FAIL line_count_seq: %0d bad samples, want 0", pix_err);
        end
        n_cmp++;
        if (vid_n != 1280) begin
            n_fail++; $display("FAIL line_video_on: %0d cycles, want 1280", vid_n);
        end
        n_cmp++;
        if (hs_n != 40 || hs_first != 1390 || hs_last != 1429 || hs_err != 0) begin
            n_fail++;
            $display("FAIL line_hsync: n=%0d first=%0d last=%0d err=%0d want 40/1390/1429/0",
                     hs_n, hs_first, hs_last, hs_err);
        end
        n_cmp++;
        if (ls_n != 1) begin
            n_fail++; $display("FAIL line_start_count: %0d, want 1", ls_n);
        end
        n_cmp++;
        if (d_pix !== 12'd0 || d_line !== 12'd2) begin
            n_fail++; $display("FAIL line_wrap: got %0d/%0d want 0/2", d_pix, d_line);
        end
    endtask

    task automatic test_en_hold();
        logic [28:0] snap;
        // Pulse hold: freeze while line_start is high.
        n_cmp++;
        if (d_ls !== 1'b1) begin
            n_fail++; $display("FAIL hold_pre_ls: got %b want 1", d_ls);
        end
        d_en = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (d_ls !== 1'b1 || d_pix !== 12'd0) begin
            n_fail++; $display("FAIL hold_pulse: ls=%b pix=%0d want 1 0", d_ls, d_pix);
        end
        d_en = 1'b1;
        step();
        n_cmp++;
        if (d_ls !== 1'b0 || d_pix !== 12'd1) begin
            n_fail++; $display("FAIL hold_resume: ls=%b pix=%0d want 0 1", d_ls, d_pix);
        end
        // Freeze at the last active pixel.
        run_to_d(1279, 2, 2000);
        snap = {12'd1279, 12'd2, 5'b10000};
        d_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if ({d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs} !== snap) begin
                n_fail++;
                $display("FAIL hold_frozen[%0d]: got %h want %h", i,
                         {d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs}, snap);
            end
        end
        d_en = 1'b1;
        step();
        n_cmp++;
        if (d_pix !== 12'd1280 || d_vid !== 1'b0) begin
            n_fail++; $display("FAIL hold_video_fall: pix=%0d vid=%b want 1280 0", d_pix, d_vid);
        end
    endtask

    task automatic test_async_reset();
        run_to_d(900, 3, 4000);
        #2;
        d_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs} !== {12'd0, 12'd0, 5'b00000}) begin
            n_fail++;
            $display("FAIL async_reset: got %0d/%0d %b%b%b%b%b want 0/0 00000",
                     d_pix, d_line, d_vid, d_hs, d_vs, d_ls, d_fs);
        end
        step();
        n_cmp++;
        if (d_pix !== 12'd0 || d_vid !== 1'b0 || d_fs !== 1'b0) begin
            n_fail++; $display("FAIL reset_held: pix=%0d vid=%b fs=%b want 0 0 0", d_pix, d_vid, d_fs);
        end
        d_rst_n = 1'b1;
        step();
        n_cmp++;
        if ({d_pix, d_line, d_vid, d_ls, d_fs} !== {12'd0, 12'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL restart: got %0d/%0d vid=%b ls=%b fs=%b want 0/0 1 1 1",
                     d_pix, d_line, d_vid, d_ls, d_fs);
        end
        step();
        n_cmp++;
        if (d_pix !== 12'd1 || d_fs !== 1'b0) begin
            n_fail++; $display("FAIL restart_next: pix=%0d fs=%b want 1 0", d_pix, d_fs);
        end
    endtask

    // Three full frames of the small instance against a position model.
    task automatic test_small_frames();
        int cnt_err = 0, hs_err = 0, vs_err = 0, vid_err = 0, ls_err = 0, vs_chg_err = 0;
        int fs_n = 0, fs_prev = -1, fs_gap_err = 0, vid_late = 0;
        int ep, el;
        logic vs_prev = 1'b1;
        s_rst_n = 1'b1;
        step();
        for (int k = 0; k < 3 * 98; k++) begin
            ep = k % 14;
            el = (k / 14) % 7;
            if (s_pix !== 12'(ep) || s_line !== 12'(el)) cnt_err++;
            if (s_hs !== ((ep == 10 || ep == 11) ? 1'b0 : 1'b1)) hs_err++;
            if (s_vs !== ((el == 5) ? 1'b0 : 1'b1)) vs_err++;
            if (s_vid !== ((ep < 8 && el < 4) ? 1'b1 : 1'b0)) vid_err++;
            if (s_vid === 1'b1 && s_line >= 12'd4) vid_late++;
            if (s_ls !== ((ep == 0) ? 1'b1 : 1'b0)) ls_err++;
            if (k > 0 && s_vs !== vs_prev && s_pix !== 12'd0) vs_chg_err++;
            vs_prev = s_vs;
            if (s_fs === 1'b1) begin
                if (fs_prev >= 0 && (k - fs_prev) != 98) fs_gap_err++;
                fs_prev = k;
                fs_n++;
            end
            step();
        end
        n_cmp++;
        if (cnt_err != 0) begin
            n_fail++; $display("FAIL small_counters: %0d bad samples, want 0", cnt_err);
        end
        n_cmp++;
        if (hs_err != 0) begin
            n_fail++; $display("FAIL small_hsync: %0d bad samples, want 0", hs_err);
        end
        n_cmp++;
        if (vs_err != 0 || vs_chg_err != 0) begin
            n_fail++; $display("FAIL small_vsync: err=%0d chg_err=%0d want 0/0", vs_err, vs_chg_err);
        end
        n_cmp++;
        if (vid_err != 0 || vid_late != 0) begin
            n_fail++; $display("FAIL small_video_on: err=%0d late=%0d want 0/0", vid_err, vid_late);
        end
        n_cmp++;
        if (ls_err != 0) begin
            n_fail++; $display("FAIL small_line_start: %0d bad samples, want 0", ls_err);
        end
        n_cmp++;
        if (fs_n != 3 || fs_gap_err != 0) begin
            n_fail++; $display("FAIL small_frame_start: n=%0d gap_err=%0d want 3/0", fs_n, fs_gap_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_line();
        test_en_hold();
        test_async_reset();
        test_small_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
